ddr3_port_arbiter: RTL and testbench
====================================

# ddr3_port_arbiter

Parametrised N-channel arbiter that multiplexes burst read/write requests from video, Ethernet and UART-debug clients onto the single command/data port of the DDR3 memory controller. It is the successor to the fixed two-client hookup. Channel count, address, data and burst widths are now parameters. Arbitration is round-robin, with an optional fixed-priority display channel. It sits between the client FIFOs and the DDR3 controller, in the `core_clk` domain.

## Interface
Parameters:
- `CH`, 4, number of client channels (2..8)
- `AW`, 28, byte address width
- `DW`, 128, data beat width
- `BLW`, 8, burst-length field width; the field holds beats minus 1

Ports:
- `core_clk`  in  1  sole clock. One clock; reset is asynchronous and active-low.
- `nrst`  in  1  asynchronous active-low reset
- `ch_req`  in  CH  per-channel request; held high until `ch_gnt`
- `ch_wr`  in  CH  1 = write, 0 = read
- `ch_addr`  in  CH*AW  packed request address
- `ch_len`  in  CH*BLW  packed burst length minus 1
- `ch_gnt`  out  CH  one-hot, one-cycle pulse on command acceptance
- `ch_wdata`  in  CH*DW  packed write data
- `ch_wvalid`  in  CH  write beat valid
- `ch_wready`  out  CH  write beat taken
- `ch_rdata`  out  DW  read data, broadcast to all channels
- `ch_rvalid`  out  CH  one-hot read beat strobe
- `mc_cmd_valid`/`mc_cmd_ready`  out/in  1  command handshake
- `mc_cmd_wr`, `mc_cmd_addr`, `mc_cmd_len`  out  1/AW/BLW  command fields
- `mc_wdata`, `mc_wvalid`  out  DW/1; `mc_wready`  in  1
- `mc_rdata`  in  DW; `mc_rvalid`  in  1
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, CMD, WDATA, RDATA. Only one transaction is outstanding at a time.
- IDLE: if any `ch_req` is high, pick a winner starting from `rr_ptr`. Register the winner index in `sel` and its wr/addr/len into the command registers, load `beat_cnt` = len, then go to CMD.
- CMD: `mc_cmd_valid`=1 with stable fields.
  - On `mc_cmd_ready`: pulse `ch_gnt[sel]`, set `rr_ptr` = (sel+1) mod CH, and go to WDATA if the command is a write, else RDATA.
  - `mc_cmd_valid` is never withdrawn before ready.
- WDATA: combinational path.
  - `mc_wdata`=`ch_wdata[sel]`, `mc_wvalid`=`ch_wvalid[sel]`, `ch_wready[sel]`=`mc_wready`.
  - Each `mc_wvalid&&mc_wready` is a beat. If `beat_cnt`==0 on a beat, go to IDLE; otherwise decrement.
- RDATA: `ch_rdata`=`mc_rdata` and `ch_rvalid[sel]`=`mc_rvalid`. Beat counting is as in WDATA.
- Ignored stimulus:
  - `mc_rvalid` outside RDATA is ignored and not forwarded.
  - `ch_wvalid` outside WDATA is ignored.
- If a client drops `ch_req` after capture in IDLE, the captured command still completes. This is a protocol violation that is tolerated, not detected.
- Width rules:
  - `beat_cnt` is BLW bits wide; len=2^BLW−1 gives 2^BLW beats.
  - `rr_ptr` is $clog2(CH) bits and wraps CH−1 → 0.

## Timing
- Reset, asynchronous while `nrst`=0:
  - state is IDLE and `rr_ptr`, `sel`, `beat_cnt` are 0
  - all outputs are 0; `ch_rdata` and `mc_wdata` are 0 because the select is gated by state
- Reset asserted mid-burst aborts the transaction immediately, with no further beats or grants.
- Request-to-`mc_cmd_valid` latency is 1 cycle: request seen in IDLE at cycle n, valid at n+1.
- `ch_gnt` is coincident with the `mc_cmd_valid&&mc_cmd_ready` cycle.
- After the last beat, the FSM is back in IDLE at the next edge. The next `mc_cmd_valid` follows 2 cycles after the last beat cycle.
- Data paths in WDATA and RDATA have zero latency (combinational). There is no buffering.
- Simultaneous requests are served in round-robin order from `rr_ptr`. A request arriving in the IDLE cycle is eligible that cycle.

## Configuration
- `ARB_QOS_EN` defined:
  - channel 0 wins whenever `ch_req[0]` is high in IDLE
  - channels 1..CH−1 are served round-robin
  - a channel-0 grant does not move `rr_ptr`; the pointer only spans 1..CH−1 and wraps to 1
- Undefined: pure round-robin over all CH channels.

## Structure
- Package `ddr3_arb_pkg`: state enum (IDLE/CMD/WDATA/RDATA) and default-parameter localparams.
- One sub-module, `rr_pick`: combinational rotate-priority encoder. It takes `req` and `ptr` and outputs a one-hot winner plus its index, and is instantiated once.

## Test plan
- Single read, ch2, len=3, `mc_cmd_ready` held high → gnt[2] one cycle after req; exactly 4 `ch_rvalid[2]` pulses; `busy` falls after the 4th beat.
- All four channels request at once from reset, with `ARB_QOS_EN` off → grants in order 0,1,2,3; `rr_ptr` ends at 0.
- `ARB_QOS_EN` on, ch0 re-requests continuously while ch1 and ch3 also request → ch0 wins every IDLE cycle; when ch0 is not requesting, ch1 then ch3 are granted.
- Write, len=255, `mc_wready` toggling every cycle → exactly 256 beats accepted; data order is preserved; IDLE after the 256th beat.
- `mc_cmd_ready` held low for 10 cycles → `mc_cmd_valid` and the fields stay stable; no `ch_gnt` until ready.
- `nrst` pulsed low in the middle of a len=7 read → all outputs 0 immediately; stray `mc_rvalid` after reset does not produce `ch_rvalid`.

Source files
------------

// File: rtl/ddr3_arb_pkg.sv
// Shared types and default parameters for the DDR3 port arbiter.
package ddr3_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } arb_state_t;

    localparam int DEF_CH  = 4;
    localparam int DEF_AW  = 28;
    localparam int DEF_DW  = 128;
    localparam int DEF_BLW = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder: first requester at or after ptr wins.
module rr_pick #(
    parameter int CH = 4,
    parameter int PW = 2
) (
    input  logic [CH-1:0] req,
    input  logic [PW-1:0] ptr,
    output logic [CH-1:0] gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = 0; i < CH; i++) begin
            j = (int'(ptr) + i) % CH;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// N-channel round-robin arbiter onto a single DDR3 controller port.
// Define ARB_QOS_EN to give channel 0 absolute priority over a 1..CH-1 rotation.
module ddr3_port_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int CH  = DEF_CH,
    parameter int AW  = DEF_AW,
    parameter int DW  = DEF_DW,
    parameter int BLW = DEF_BLW
) (
    input  logic                    core_clk,
    input  logic                    nrst,
    input  logic [CH-1:0]           ch_req,
    input  logic [CH-1:0]           ch_wr,
    input  logic [CH*AW-1:0]        ch_addr,
    input  logic [CH*BLW-1:0]       ch_len,
    output logic [CH-1:0]           ch_gnt,
    input  logic [CH*DW-1:0]        ch_wdata,
    input  logic [CH-1:0]           ch_wvalid,
    output logic [CH-1:0]           ch_wready,
    output logic [DW-1:0]           ch_rdata,
    output logic [CH-1:0]           ch_rvalid,
    output logic                    mc_cmd_valid,
    input  logic                    mc_cmd_ready,
    output logic                    mc_cmd_wr,
    output logic [AW-1:0]           mc_cmd_addr,
    output logic [BLW-1:0]          mc_cmd_len,
    output logic [DW-1:0]           mc_wdata,
    output logic                    mc_wvalid,
    input  logic                    mc_wready,
    input  logic [DW-1:0]           mc_rdata,
    input  logic                    mc_rvalid,
    output logic                    busy,
    output logic [1:0]              dbg_state,
    output logic [$clog2(CH)-1:0]   dbg_rr_ptr
);

    localparam int PW = $clog2(CH);

    // Handshake: a command transfers on mc_cmd_valid && mc_cmd_ready, a write
    // beat on mc_wvalid && mc_wready, a read beat on mc_rvalid (no backpressure).
    arb_state_t     state, state_nxt;
    logic [PW-1:0]  sel, rr_ptr, pick_idx, win_idx;
    logic [CH-1:0]  pick_req, pick_gnt, win_oh;
    logic           pick_any, win_any;
    logic           win_wr, cmd_wr;
    logic [AW-1:0]  win_addr, cmd_addr;
    logic [BLW-1:0] win_len, cmd_len, beat_cnt;
    logic           beat;

`ifdef ARB_QOS_EN
    assign pick_req = {ch_req[CH-1:1], 1'b0};
    assign win_any  = ch_req[0] | pick_any;
    assign win_oh   = ch_req[0] ? CH'(1) : pick_gnt;
    assign win_idx  = ch_req[0] ? '0 : pick_idx;
`else
    assign pick_req = ch_req;
    assign win_any  = pick_any;
    assign win_oh   = pick_gnt;
    assign win_idx  = pick_idx;
`endif

    rr_pick #(.CH(CH), .PW(PW)) u_rr_pick (
        .req (pick_req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        win_wr   = 1'b0;
        win_addr = '0;
        win_len  = '0;
        for (int i = 0; i < CH; i++) begin
            if (win_oh[i]) begin
                win_wr   = ch_wr[i];
                win_addr = ch_addr[i*AW +: AW];
                win_len  = ch_len[i*BLW +: BLW];
            end
        end
    end

    assign beat = ((state == WDATA) && ch_wvalid[sel] && mc_wready) ||
                  ((state == RDATA) && mc_rvalid);

    always_ff @(posedge core_clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_any) state_nxt = CMD;
            CMD:     if (mc_cmd_ready) state_nxt = cmd_wr ? WDATA : RDATA;
            WDATA,
            RDATA:   if (beat && beat_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge core_clk or negedge nrst) begin
        if (!nrst) begin
            sel      <= '0;
            rr_ptr   <= '0;
            cmd_wr   <= 1'b0;
            cmd_addr <= '0;
            cmd_len  <= '0;
            beat_cnt <= '0;
        end else begin
            if (state == IDLE && win_any) begin
                sel      <= win_idx;
                cmd_wr   <= win_wr;
                cmd_addr <= win_addr;
                cmd_len  <= win_len;
                beat_cnt <= win_len;
            end
            if (state == CMD && mc_cmd_ready) begin
`ifdef ARB_QOS_EN
                // Channel 0 sits outside the rotation, so its grants leave the pointer alone.
                if (sel != '0)
                    rr_ptr <= (int'(sel) == CH-1) ? PW'(1) : sel + 1'b1;
`else
                rr_ptr <= (int'(sel) == CH-1) ? '0 : sel + 1'b1;
`endif
            end
            if (beat && beat_cnt != '0)
                beat_cnt <= beat_cnt - 1'b1;
        end
    end

    // Every client-facing and controller-facing path is gated by state, so reset forces zeros.
    always_comb begin
        ch_gnt       = '0;
        ch_wready    = '0;
        ch_rdata     = '0;
        ch_rvalid    = '0;
        mc_cmd_valid = 1'b0;
        mc_cmd_wr    = 1'b0;
        mc_cmd_addr  = '0;
        mc_cmd_len   = '0;
        mc_wdata     = '0;
        mc_wvalid    = 1'b0;
        case (state)
            CMD: begin
                mc_cmd_valid = 1'b1;
                mc_cmd_wr    = cmd_wr;
                mc_cmd_addr  = cmd_addr;
                mc_cmd_len   = cmd_len;
                if (mc_cmd_ready) ch_gnt[sel] = 1'b1;
            end
            WDATA: begin
                mc_wdata       = ch_wdata[int'(sel)*DW +: DW];
                mc_wvalid      = ch_wvalid[sel];
                ch_wready[sel] = mc_wready;
            end
            RDATA: begin
                ch_rdata       = mc_rdata;
                ch_rvalid[sel] = mc_rvalid;
            end
            default: ;
        endcase
    end

    assign busy       = (state != IDLE);
    assign dbg_state  = state;
    assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Scoreboard bench for ddr3_port_arbiter: drivers push expectations, a negedge monitor pops and compares.
module tb_ddr3_port_arbiter;
    import ddr3_arb_pkg::*;

    localparam int CH = 4, AW = 28, DW = 128, BLW = 8, PW = 2;

    logic              core_clk = 1'b0;
    logic              nrst;
    logic [CH-1:0]     ch_req, ch_wr, ch_gnt, ch_wvalid, ch_wready, ch_rvalid;
    logic [CH*AW-1:0]  ch_addr;
    logic [CH*BLW-1:0] ch_len;
    logic [CH*DW-1:0]  ch_wdata;
    logic [DW-1:0]     ch_rdata, mc_wdata, mc_rdata;
    logic              mc_cmd_valid, mc_cmd_ready, mc_cmd_wr, mc_wvalid, mc_wready, mc_rvalid, busy;
    logic [AW-1:0]     mc_cmd_addr;
    logic [BLW-1:0]    mc_cmd_len;
    logic [1:0]        dbg_state;
    logic [PW-1:0]     dbg_rr_ptr;

    logic [CH-1:0]       exp_gnt_q[$];
    logic [AW+BLW:0]     exp_cmd_q[$];
    logic [CH+DW-1:0]    exp_rd_q[$];
    logic [CH+DW-1:0]    exp_wr_q[$];
    int                  n_pass = 0, n_total = 0;
    int                  rd_cnt[CH];

    ddr3_port_arbiter #(.CH(CH), .AW(AW), .DW(DW), .BLW(BLW)) dut (
        .core_clk(core_clk), .nrst(nrst),
        .ch_req(ch_req), .ch_wr(ch_wr), .ch_addr(ch_addr), .ch_len(ch_len), .ch_gnt(ch_gnt),
        .ch_wdata(ch_wdata), .ch_wvalid(ch_wvalid), .ch_wready(ch_wready),
        .ch_rdata(ch_rdata), .ch_rvalid(ch_rvalid),
        .mc_cmd_valid(mc_cmd_valid), .mc_cmd_ready(mc_cmd_ready), .mc_cmd_wr(mc_cmd_wr),
        .mc_cmd_addr(mc_cmd_addr), .mc_cmd_len(mc_cmd_len),
        .mc_wdata(mc_wdata), .mc_wvalid(mc_wvalid), .mc_wready(mc_wready),
        .mc_rdata(mc_rdata), .mc_rvalid(mc_rvalid),
        .busy(busy), .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
    );

    // ---------------- clock / watchdog ----------------
    always #5 core_clk = ~core_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- check helpers ----------------
    task automatic check(string name, logic [255:0] act, logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic fail(string name, logic [255:0] act);
        n_total++;
        $display("FAIL %s: got %0h, required no event", name, act);
    endtask

    function automatic logic [CH-1:0] oh(int c);
        logic [CH-1:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    function automatic logic [DW-1:0] rdata(int b);
        return {4{32'h5EED0000 + 32'(b)}};
    endfunction

    function automatic logic [DW-1:0] wdata(int k);
        return {4{32'hC0DE0000 + 32'(k)}};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge core_clk) begin
        if (ch_gnt != '0) begin
            if (exp_gnt_q.size() == 0) fail("gnt_unexpected", ch_gnt);
            else check("gnt", ch_gnt, exp_gnt_q.pop_front());
        end
        if (mc_cmd_valid && mc_cmd_ready) begin
            if (exp_cmd_q.size() == 0) fail("cmd_unexpected", mc_cmd_addr);
            else check("cmd", {mc_cmd_wr, mc_cmd_addr, mc_cmd_len}, exp_cmd_q.pop_front());
        end
        if (ch_rvalid != '0) begin
            for (int i = 0; i < CH; i++) if (ch_rvalid[i]) rd_cnt[i]++;
            if (exp_rd_q.size() == 0) fail("rd_unexpected", {ch_rvalid, ch_rdata});
            else check("rd_beat", {ch_rvalid, ch_rdata}, exp_rd_q.pop_front());
        end
        if (mc_wvalid && mc_wready) begin
            if (exp_wr_q.size() == 0) fail("wr_unexpected", {ch_wready, mc_wdata});
            else check("wr_beat", {ch_wready, mc_wdata}, exp_wr_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge core_clk);
        #1;
    endtask

    task automatic issue(int c, logic wr, logic [AW-1:0] addr, logic [BLW-1:0] len);
        ch_req[c]              = 1'b1;
        ch_wr[c]               = wr;
        ch_addr[c*AW +: AW]    = addr;
        ch_len[c*BLW +: BLW]   = len;
    endtask

    task automatic expect_cmd(int c, logic wr, logic [AW-1:0] addr, logic [BLW-1:0] len);
        exp_gnt_q.push_back(oh(c));
        exp_cmd_q.push_back({wr, addr, len});
    endtask

    task automatic wait_gnt(output int lat);
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge core_clk);
            if (ch_gnt != '0) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) fail("gnt_timeout", 256'd0);
    endtask

    task automatic serve_read(int c, int n, int base);
        for (int b = 0; b < n; b++) begin
            mc_rdata  = rdata(base + b);
            mc_rvalid = 1'b1;
            exp_rd_q.push_back({oh(c), rdata(base + b)});
            step();
        end
        mc_rvalid = 1'b0;
    endtask

    task automatic check_reset_outputs(string name);
        check({name, "_ctl"}, {ch_gnt, ch_wready, ch_rvalid, mc_cmd_valid, mc_cmd_wr, mc_wvalid, busy}, '0);
        check({name, "_state"}, {dbg_state, dbg_rr_ptr}, '0);
        check({name, "_data"}, {ch_rdata, mc_wdata}, '0);
        check({name, "_cmd"}, {mc_cmd_addr, mc_cmd_len}, '0);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        #1;
        check_reset_outputs("reset");
        step();
        nrst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int lat;
    int k, tog, cyc;
`ifdef ARB_QOS_EN
    int qos_order[5] = '{0, 0, 0, 1, 3};
`endif

    initial begin
        ch_req = '0; ch_wr = '0; ch_addr = '0; ch_len = '0; ch_wdata = '0; ch_wvalid = '0;
        mc_cmd_ready = 1'b1; mc_wready = 1'b0; mc_rvalid = 1'b0;
        mc_rdata = {4{32'hDEADBEEF}};
        for (int i = 0; i < CH; i++) rd_cnt[i] = 0;
        nrst = 1'b0;
        repeat (2) @(posedge core_clk);
        #1;
        check_reset_outputs("por");
        nrst = 1'b1;
        step();

        // stray data-path strobes while idle
        mc_rvalid = 1'b1;
        ch_wvalid = '1;
        @(negedge core_clk);
        check("idle_rvalid_gated", {ch_rvalid, ch_rdata}, '0);
        check("idle_wvalid_gated", {mc_wvalid, mc_wdata, ch_wready}, '0);
        step();
        mc_rvalid = 1'b0;
        ch_wvalid = '0;

        // single read, ch2, len=3
        issue(2, 1'b0, 28'h0123450, 8'd3);
        expect_cmd(2, 1'b0, 28'h0123450, 8'd3);
        wait_gnt(lat);
        check("t1_gnt_latency", lat, 2);
        step();
        ch_req[2] = 1'b0;
        serve_read(2, 4, 0);
        @(negedge core_clk);
        check("t1_busy_fall", busy, 1'b0);
        check("t1_beat_count", rd_cnt[2], 4);
        step();

        // simultaneous requests from reset
        do_reset();
`ifndef ARB_QOS_EN
        for (int c = 0; c < CH; c++) begin
            issue(c, 1'b0, AW'(28'h0100000 + c * 28'h100), 8'd0);
            expect_cmd(c, 1'b0, AW'(28'h0100000 + c * 28'h100), 8'd0);
        end
        for (int c = 0; c < CH; c++) begin
            wait_gnt(lat);
            step();
            ch_req[c] = 1'b0;
            serve_read(c, 1, 16 * c);
        end
        @(negedge core_clk);
        check("t2_rr_ptr_end", dbg_rr_ptr, 0);
`else
        issue(0, 1'b0, 28'h0200000, 8'd0);
        issue(1, 1'b0, 28'h0200100, 8'd0);
        issue(3, 1'b0, 28'h0200300, 8'd0);
        for (int i = 0; i < 5; i++)
            expect_cmd(qos_order[i], 1'b0, AW'(28'h0200000 + qos_order[i] * 28'h100), 8'd0);
        for (int i = 0; i < 5; i++) begin
            wait_gnt(lat);
            step();
            if (i >= 2) ch_req[qos_order[i]] = 1'b0;
            serve_read(qos_order[i], 1, 16 * i);
        end
        @(negedge core_clk);
        check("t2q_rr_ptr_end", dbg_rr_ptr, 1);
`endif
        step();

        // long write, ch1, len=255, mc_wready toggling
        issue(1, 1'b1, 28'h0800000, 8'd255);
        expect_cmd(1, 1'b1, 28'h0800000, 8'd255);
        for (int i = 0; i < 256; i++) exp_wr_q.push_back({oh(1), wdata(i)});
        wait_gnt(lat);
        step();
        ch_req[1] = 1'b0;
        k = 0; tog = 0; cyc = 0;
        while (k < 256 && cyc < 1000) begin
            ch_wdata[DW +: DW] = wdata(k);
            ch_wvalid[1]       = 1'b1;
            mc_wready          = tog[0];
            step();
            if (tog != 0) k++;
            tog = 1 - tog;
            cyc++;
        end
        ch_wvalid = '0;
        mc_wready = 1'b0;
        @(negedge core_clk);
        check("t4_idle_after_last", dbg_state, IDLE);
        check("t4_busy_low", busy, 1'b0);
        step();

        // command backpressure, ch3 read len=1
        mc_cmd_ready = 1'b0;
        issue(3, 1'b0, 28'hABCDEF0, 8'd1);
        expect_cmd(3, 1'b0, 28'hABCDEF0, 8'd1);
        @(negedge core_clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge core_clk);
            check("t5_cmd_valid_held", mc_cmd_valid, 1'b1);
            check("t5_fields_stable", {mc_cmd_wr, mc_cmd_addr, mc_cmd_len}, {1'b0, 28'hABCDEF0, 8'd1});
            check("t5_no_gnt", ch_gnt, '0);
        end
        step();
        mc_cmd_ready = 1'b1;
        wait_gnt(lat);
        check("t5_gnt_on_ready", lat, 1);
        step();
        ch_req[3] = 1'b0;
        serve_read(3, 2, 100);

        // reset in the middle of a len=7 read on ch0
        issue(0, 1'b0, 28'h0000100, 8'd7);
        expect_cmd(0, 1'b0, 28'h0000100, 8'd7);
        wait_gnt(lat);
        step();
        ch_req[0] = 1'b0;
        serve_read(0, 3, 200);
        mc_rdata  = rdata(203);
        mc_rvalid = 1'b1;
        nrst      = 1'b0;
        #1;
        check_reset_outputs("t6_midburst");
        step();
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge core_clk);
            check("t6_stray_rvalid", {ch_rvalid, ch_rdata, busy}, '0);
        end
        step();
        mc_rvalid = 1'b0;
        repeat (2) step();

        // ---------------- final report ----------------
        check("gnt_q_drained", exp_gnt_q.size(), 0);
        check("cmd_q_drained", exp_cmd_q.size(), 0);
        check("rd_q_drained", exp_rd_q.size(), 0);
        check("wr_q_drained", exp_wr_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
